// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes stage. Accepts a 128-bit state on a valid/ready
// handshake and substitutes SBOX_LANES bytes per cycle through shared S-box
// lookups, then presents the result on a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid/o_ready      upstream handshake, i_state 128-bit input state
//   o_valid/i_ready      downstream handshake, o_state 128-bit result
//   o_busy               block holds a state (BUSY or DONE)
// Byte k of a state sits at bits [127-8k -: 8].
module sub_bytes_seq #(
  parameter int unsigned SBOX_LANES = 4,
  parameter bit          INVERSE    = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_state,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state,
  output logic         o_busy
);

  localparam int unsigned NCHUNK = 16 / SBOX_LANES;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Table entry k lives at bits [8*(255-k) +: 8].
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    work_sub;

  // Combinational S-box lookup, direction fixed at elaboration.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    if (INVERSE) return SBOX_INV[8*(255-int'(b)) +: 8];
    else         return SBOX_FWD[8*(255-int'(b)) +: 8];
  endfunction

  // Substitute the chunk selected by cnt_q in place; other bytes pass through.
  always_comb begin
    work_sub = work_q;
    for (int l = 0; l < int'(SBOX_LANES); l++) begin
      work_sub[8*(15-(int'(cnt_q)*int'(SBOX_LANES)+l)) +: 8] =
        sbox_lookup(work_q[8*(15-(int'(cnt_q)*int'(SBOX_LANES)+l)) +: 8]);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          work_d  = i_state;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d = work_sub;
        if (cnt_q == CW'(NCHUNK-1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; handshake flags are registered decodes of the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      o_ready <= (state_d == S_IDLE);
      o_valid <= (state_d == S_DONE);
      o_busy  <= (state_d != S_IDLE);
    end
  end

  assign o_state = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

  localparam int NA = 4;   // chunks for the SBOX_LANES=4 instance

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SBOX_LANES=4 forward (random + directed, per-cycle model check)
  logic         a_vld_in = 1'b0, a_rdy_in = 1'b0;
  logic [127:0] a_st_in = '0;
  logic         a_rdy_out, a_vld_out, a_busy;
  logic [127:0] a_st_out;
  // Instance B: SBOX_LANES=1 forward
  logic         b_vld_in = 1'b0;
  logic [127:0] b_st_in = '0;
  logic         b_rdy_out, b_vld_out, b_busy;
  logic [127:0] b_st_out;
  // Instance C: SBOX_LANES=16 inverse
  logic         c_vld_in = 1'b0;
  logic [127:0] c_st_in = '0;
  logic         c_rdy_out, c_vld_out, c_busy;
  logic [127:0] c_st_out;

  sub_bytes_seq #(.SBOX_LANES(4), .INVERSE(1'b0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_vld_in), .o_ready(a_rdy_out),
    .i_state(a_st_in), .o_valid(a_vld_out), .i_ready(a_rdy_in),
    .o_state(a_st_out), .o_busy(a_busy));

  sub_bytes_seq #(.SBOX_LANES(1), .INVERSE(1'b0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_vld_in), .o_ready(b_rdy_out),
    .i_state(b_st_in), .o_valid(b_vld_out), .i_ready(1'b1),
    .o_state(b_st_out), .o_busy(b_busy));

  sub_bytes_seq #(.SBOX_LANES(16), .INVERSE(1'b1)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_vld_in), .o_ready(c_rdy_out),
    .i_state(c_st_in), .o_valid(c_vld_out), .i_ready(1'b1),
    .o_state(c_st_out), .o_busy(c_busy));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: S-box from GF(2^8) arithmetic ----------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
  endfunction

  // State with its first nbytes bytes substituted.
  function automatic logic [127:0] sub_prefix(input logic [127:0] s, input int nbytes, input bit inv);
    logic [127:0] r;
    r = s;
    for (int k = 0; k < nbytes; k++)
      r[127-8*k -: 8] = inv ? inv_t[s[127-8*k -: 8]] : fwd_t[s[127-8*k -: 8]];
    return r;
  endfunction

  // Transaction-level model of instance A: holding flag, edges since accept, last result.
  logic         m_hold = 1'b0;
  int           m_el   = 0;
  logic [127:0] m_in   = '0;
  logic [127:0] m_last = '0;
  bit           cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0; m_el <= 0; m_in <= '0; m_last <= '0;
    end else if (!m_hold) begin
      if (a_vld_in) begin
        m_hold <= 1'b1; m_el <= 0; m_in <= a_st_in;
      end
    end else if (m_el < NA) begin
      m_el <= m_el + 1;
    end else if (a_rdy_in) begin
      m_hold <= 1'b0;
      m_last <= sub_prefix(m_in, 16, 1'b0);
    end
  end

  // Per-cycle compare of instance A against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic         ev;
      logic [127:0] es;
      ev = m_hold && (m_el == NA);
      es = m_hold ? sub_prefix(m_in, m_el * 4, 1'b0) : m_last;
      chk("a_o_valid", 128'(a_vld_out), 128'(ev));
      chk("a_o_ready", 128'(a_rdy_out), 128'(!m_hold));
      chk("a_o_busy",  128'(a_busy),    128'(m_hold));
      chk("a_o_state", a_st_out, es);
    end
  end

  // Wait (bounded) for A's o_valid; returns edges counted from the accept edge's negedge.
  task automatic wait_a_valid(output int cyc);
    cyc = 0;
    while (!a_vld_out && cyc < 100) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    if (!a_vld_out) chk("a_valid_timeout", 128'(a_vld_out), 128'd1);
  endtask

  task automatic a_accept(input logic [127:0] s);
    a_vld_in = 1'b1; a_st_in = s;
    @(posedge clk); @(negedge clk);
    a_vld_in = 1'b0; a_st_in = 128'($urandom);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    int cyc;
    logic [127:0] x, y, w;

    for (int i = 0; i < 256; i++) fwd_t[i] = affine(ginv(8'(i)));
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

    // Pin the model with known FIPS-197 values.
    chk("model_sbox_00", 128'(fwd_t[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(fwd_t[8'h53]), 128'hed);
    chk("model_fips_fwd", sub_prefix(FIPS_IN, 16, 1'b0), FIPS_OUT);
    chk("model_fips_inv", sub_prefix(FIPS_OUT, 16, 1'b1), FIPS_IN);

    repeat (3) @(negedge clk);
    chk("rst_a_ready", 128'(a_rdy_out), 128'd1);
    chk("rst_a_valid", 128'(a_vld_out), 128'd0);
    chk("rst_a_busy",  128'(a_busy),    128'd0);
    chk("rst_a_state", a_st_out, 128'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // FIPS-197 App.B round 1, latency and backpressure.
    a_accept(FIPS_IN);
    wait_a_valid(cyc);
    chk("fips_latency", 128'(cyc), 128'(NA));
    chk("fips_result", a_st_out, FIPS_OUT);
    repeat (10) @(negedge clk);
    chk("bp_valid_held", 128'(a_vld_out), 128'd1);
    chk("bp_ready_low",  128'(a_rdy_out), 128'd0);
    chk("bp_state_held", a_st_out, FIPS_OUT);
    a_rdy_in = 1'b1;
    @(negedge clk);
    a_rdy_in = 1'b0;
    chk("bp_ready_after", 128'(a_rdy_out), 128'd1);
    chk("bp_valid_after", 128'(a_vld_out), 128'd0);

    // New input while busy is ignored; accepted only after the return to IDLE.
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    a_accept(x);
    a_vld_in = 1'b1; a_st_in = y;
    wait_a_valid(cyc);
    chk("busy_ignore_result", a_st_out, sub_prefix(x, 16, 1'b0));
    a_rdy_in = 1'b1;
    @(negedge clk);
    chk("xfer_no_accept", 128'(a_busy), 128'd0);
    a_rdy_in = 1'b0;
    @(negedge clk);
    chk("second_accepted", 128'(a_busy), 128'd1);
    a_vld_in = 1'b0;
    wait_a_valid(cyc);
    chk("second_result", a_st_out, sub_prefix(y, 16, 1'b0));
    a_rdy_in = 1'b1;
    @(negedge clk);
    a_rdy_in = 1'b0;

    // Async reset mid-BUSY (cnt=2).
    a_accept({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(a_vld_out), 128'd0);
    chk("arst_state", a_st_out, 128'h0);
    chk("arst_ready", 128'(a_rdy_out), 128'd1);
    chk("arst_busy",  128'(a_busy),    128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = {$urandom, $urandom, $urandom, $urandom};
    a_accept(w);
    wait_a_valid(cyc);
    chk("post_rst_latency", 128'(cyc), 128'(NA));
    chk("post_rst_result", a_st_out, sub_prefix(w, 16, 1'b0));
    a_rdy_in = 1'b1;
    @(negedge clk);
    a_rdy_in = 1'b0;

    // SBOX_LANES=1: all-zero state.
    b_vld_in = 1'b1; b_st_in = '0;
    @(posedge clk); @(negedge clk);
    b_vld_in = 1'b0; b_st_in = '1;
    cyc = 0;
    while (!b_vld_out && cyc < 100) begin @(posedge clk); @(negedge clk); cyc++; end
    chk("l1_latency", 128'(cyc), 128'd16);
    chk("l1_result", b_st_out, {16{8'h63}});

    // SBOX_LANES=16, INVERSE=1: FIPS result back to input, then 16{63} -> 0.
    c_vld_in = 1'b1; c_st_in = FIPS_OUT;
    @(posedge clk); @(negedge clk);
    c_vld_in = 1'b0; c_st_in = '0;
    cyc = 0;
    while (!c_vld_out && cyc < 100) begin @(posedge clk); @(negedge clk); cyc++; end
    chk("l16_inv_latency", 128'(cyc), 128'd1);
    chk("l16_inv_fips", c_st_out, FIPS_IN);
    @(negedge clk);
    c_vld_in = 1'b1; c_st_in = {16{8'h63}};
    @(posedge clk); @(negedge clk);
    c_vld_in = 1'b0;
    cyc = 0;
    while (!c_vld_out && cyc < 100) begin @(posedge clk); @(negedge clk); cyc++; end
    chk("l16_inv_63", c_st_out, 128'h0);

    // Randomized traffic on A with occasional long downstream stalls.
    begin
      int stall;
      stall = 0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        a_vld_in = ($urandom_range(0, 2) != 0);
        a_st_in  = {$urandom, $urandom, $urandom, $urandom};
        if (stall > 0) begin
          stall--;
          a_rdy_in = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          stall = $urandom_range(3, 15);
          a_rdy_in = 1'b0;
        end else begin
          a_rdy_in = ($urandom_range(0, 3) != 0);
        end
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
